// File: rtl/msg_header_streamer.sv
// msg_header_streamer: streams a little-endian message header (sync, length, ID, sequence, optional checksum)
// over a valid/ready byte handshake and keeps an auto-incrementing sequence counter.
module msg_header_streamer #(
    parameter logic [15:0] SYNC_WORD        = 16'h1234,
    parameter logic [15:0] SEQ_INIT         = 16'h0000,
    parameter bit          INCLUDE_CHECKSUM = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] id_i,
    input  logic [15:0] data_byte_count_i,
    input  logic        seq_load_i,
    input  logic [15:0] seq_load_value_i,
    input  logic        byte_ready_i,
    output logic [7:0]  header_byte_o,
    output logic        byte_valid_o,
    output logic        last_byte_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] msg_byte_count_o,
    output logic [15:0] seq_number_o
);
    localparam logic [3:0] LAST_IDX = INCLUDE_CHECKSUM ? 4'd8 : 4'd7;
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state_q;
    logic [3:0]  idx_q;
    logic [15:0] id_q, mbc_q, seq_q;
    logic        done_q;
    logic [7:0]  csum, byte_sel;
    logic        at_last;
    assign at_last = idx_q == LAST_IDX;
    // seq_q cannot change while sending, so it is the value captured at Start
    assign csum = 8'h00 - (SYNC_WORD[7:0] + SYNC_WORD[15:8] + mbc_q[7:0] + mbc_q[15:8]
                         + id_q[7:0] + id_q[15:8] + seq_q[7:0] + seq_q[15:8]);
    always_comb begin
        byte_sel = csum;
        case (idx_q)
            4'd0: byte_sel = SYNC_WORD[7:0];
            4'd1: byte_sel = SYNC_WORD[15:8];
            4'd2: byte_sel = mbc_q[7:0];
            4'd3: byte_sel = mbc_q[15:8];
            4'd4: byte_sel = id_q[7:0];
            4'd5: byte_sel = id_q[15:8];
            4'd6: byte_sel = seq_q[7:0];
            4'd7: byte_sel = seq_q[15:8];
            default: byte_sel = csum;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            id_q    <= 16'h0000;
            mbc_q   <= 16'h0000;
            seq_q   <= SEQ_INIT;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (seq_load_i) seq_q <= seq_load_value_i;
                if (start_i) begin
                    state_q <= SEND;
                    idx_q   <= 4'd0;
                    id_q    <= id_i;
                    mbc_q   <= data_byte_count_i + {12'd0, LAST_IDX} + 16'd1;
                end
            end else if (byte_ready_i) begin
                idx_q <= idx_q + 4'd1;
                if (at_last) begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    done_q  <= 1'b1;
                    seq_q   <= seq_q + 16'd1;
                end
            end
        end
    end
    assign byte_valid_o     = state_q == SEND;
    assign busy_o           = state_q == SEND;
    assign header_byte_o    = byte_valid_o ? byte_sel : 8'h00;
    assign last_byte_o      = byte_valid_o && at_last;
    assign done_o           = done_q;
    assign msg_byte_count_o = mbc_q;
    assign seq_number_o     = seq_q;
endmodule

// File: tb/tb_msg_header_streamer.sv
// tb_msg_header_streamer: directed checks of header bytes, handshake stalls, sequence handling and reset abort.
module tb_msg_header_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b0, start0 = 1'b0, start1 = 1'b0, seq_load = 1'b0, ready = 1'b1;
    logic [15:0] id = 16'h0102, cnt = 16'h0010, seq_val = 16'h0000;
    logic [7:0]  hb0, hb1;
    logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;
    logic [15:0] mbc0, mbc1, seq0, seq1;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    msg_header_streamer dut0 (
        .clk_i(clk), .reset_i(rst), .start_i(start0), .id_i(id), .data_byte_count_i(cnt),
        .seq_load_i(seq_load), .seq_load_value_i(seq_val), .byte_ready_i(ready),
        .header_byte_o(hb0), .byte_valid_o(valid0), .last_byte_o(last0), .busy_o(busy0),
        .done_o(done0), .msg_byte_count_o(mbc0), .seq_number_o(seq0)
    );

    msg_header_streamer #(.INCLUDE_CHECKSUM(1'b1)) dut1 (
        .clk_i(clk), .reset_i(rst), .start_i(start1), .id_i(id), .data_byte_count_i(cnt),
        .seq_load_i(seq_load), .seq_load_value_i(seq_val), .byte_ready_i(ready),
        .header_byte_o(hb1), .byte_valid_o(valid1), .last_byte_o(last1), .busy_o(busy1),
        .done_o(done1), .msg_byte_count_o(mbc1), .seq_number_o(seq1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dut0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Expects dut0 to be presenting byte 0; walks the 8 bytes, ends in the Done cycle.
    task automatic stream0(input string tag, input logic [63:0] e, input int stall_at,
                           input int start_at, input int load_at);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = e[63-8*i -: 8];
            if (i == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk({tag, "_hold"}, {valid0, busy0, done0, last0, hb0}, {4'b1100, b});
                    tick();
                end
                ready = 1'b1;
            end
            chk({tag, "_byte"}, {valid0, busy0, done0, last0, hb0}, {3'b110, i == 7, b});
            start0   = (i == start_at);
            seq_load = (i == load_at);
            tick();
            start0   = 1'b0;
            seq_load = 1'b0;
        end
        chk({tag, "_done"}, {valid0, busy0, done0, last0, hb0}, {4'b0010, 8'h00});
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_outs0", {valid0, busy0, done0, last0, hb0}, 12'h000);
        chk("reset_regs0", {mbc0, seq0}, 32'h0);
        chk("reset_outs1", {valid1, busy1, done1, last1, hb1, seq1}, 28'h0);

        // basic header
        start_dut0();
        stream0("basic", 64'h3412_1800_0201_0000, -1, -1, -1);
        chk("basic_seq", seq0, 16'h0001);
        chk("basic_mbc", mbc0, 16'h0018);
        tick();
        chk("basic_done_1cyc", {done0, valid0}, 2'b00);

        // stall on byte 4; inputs changed after Start must not leak in
        start_dut0();
        id  = 16'hFFFF;
        cnt = 16'hFFFF;
        stream0("stall", 64'h3412_1800_0201_0100, 4, -1, -1);
        chk("stall_seq", seq0, 16'h0002);
        id  = 16'h0102;
        cnt = 16'h0010;
        tick();

        // checksum variant
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("cs_mbc", mbc1, 16'h0019);
        for (int i = 0; i < 9; i++) begin
            logic [71:0] e;
            e = 72'h3412_1900_0201_0000_9E;
            chk("cs_byte", {valid1, last1, hb1}, {1'b1, i == 8, e[71-8*i -: 8]});
            tick();
        end
        chk("cs_done", {done1, busy1, valid1, seq1}, {3'b100, 16'h0001});
        tick();

        // sequence load and wrap; load during SEND is ignored
        seq_val  = 16'hFFFF;
        seq_load = 1'b1;
        tick();
        seq_load = 1'b0;
        chk("load_seq", seq0, 16'hFFFF);
        seq_val = 16'h1234;
        start_dut0();
        stream0("wrap_a", 64'h3412_1800_0201_FFFF, -1, -1, -1);
        chk("wrap_seq", seq0, 16'h0000);
        tick();
        start_dut0();
        stream0("wrap_b", 64'h3412_1800_0201_0000, -1, -1, 3);
        chk("wrap_seq2", seq0, 16'h0001);
        tick();

        // Start mid-header ignored, not queued
        start_dut0();
        stream0("ign", 64'h3412_1800_0201_0100, -1, 3, -1);
        tick();
        chk("ign_noqueue", {valid0, busy0, done0}, 3'b000);

        // Start in the Done cycle is accepted
        start_dut0();
        stream0("b2b_a", 64'h3412_1800_0201_0200, -1, -1, -1);
        start_dut0();
        chk("b2b_start", {valid0, busy0, hb0}, {2'b11, 8'h34});
        stream0("b2b_b", 64'h3412_1800_0201_0300, -1, -1, -1);
        chk("b2b_seq", seq0, 16'h0004);
        tick();

        // reset at byte 5 aborts with no Done and no increment
        start_dut0();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre", {valid0, hb0}, {1'b1, 8'h01});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outs", {valid0, busy0, done0, last0, hb0}, 12'h000);
        chk("abort_regs", {mbc0, seq0}, 32'h0);
        tick();
        chk("abort_nodone", {done0, valid0}, 2'b00);
        start_dut0();
        stream0("fresh", 64'h3412_1800_0201_0000, -1, -1, -1);
        chk("fresh_seq", seq0, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
